nibble_sub_seq: RTL and testbench
=================================

# nibble_sub_seq

Sequential multi-word subtractor controller that reuses a single 4-bit ripple-borrow subtractor slice over several clock cycles. It computes A − B − Bin for a W-bit operand pair one nibble per cycle, least-significant nibble first, and chains the borrow through a register between cycles. The block sits between a requesting unit (start/done handshake) and the shared 4-bit slice, trading latency for area.

## Interface

Parameters:
- N_NIBBLES, default 4: number of nibbles per operand; W = 4*N_NIBBLES (default 16). Legal range is 2..16.

Ports:
- in_clk  in  1  clock. One clock domain, rising edge.
- in_rst_n  in  1  reset. Synchronous and active-low.
- in_start  in  1  request pulse or level; sampled only when the block can accept a request.
- in_a  in  W  minuend; captured on the accepted start edge.
- in_b  in  W  subtrahend; captured on the accepted start edge.
- in_bin  in  1  borrow-in to nibble 0; captured on the accepted start edge.
- out_busy  out  1  high while in RUN.
- out_done  out  1  one-cycle pulse; the result registers are valid from this cycle onward.
- out_diff  out  W  A − B − Bin mod 2^W.
- out_bout  out  1  final borrow-out; 1 means A < B + Bin, unsigned.
- out_zero  out  1  out_diff == 0.

## Operation

- States are IDLE, RUN and DONE. The state register is 2 bits and never takes the unused encoding.
- **IDLE:** if in_start=1, capture in_a, in_b and in_bin, set idx=0 and go to RUN. Otherwise stay in IDLE.
- **RUN:** each cycle the slice computes on nibble[idx] of a_reg/b_reg with borrow_reg as its borrow-in.
  - The slice's 4-bit result is written to acc nibble[idx].
  - borrow_reg takes the slice's borrow-out.
  - idx increments.
  - When idx == N_NIBBLES−1, the transition is to DONE instead.
  - in_start is ignored in RUN and is not queued.
- **DONE:** lasts exactly one cycle, with out_done=1.
  - out_diff, out_bout and out_zero were loaded on the edge entering DONE.
  - If in_start=1 in DONE, the request is accepted back-to-back: operands are captured and the next state is RUN. Otherwise the next state is IDLE.
- **Result registers:** out_diff, out_bout and out_zero change only on the edge entering DONE. They hold their values through IDLE and through a subsequent RUN until the next DONE.
- **Arithmetic:** the borrow chain is exactly the 4-bit ripple-borrow slice cascaded in time.
  - The result equals (A − B − Bin) mod 2^W.
  - out_bout = 1 iff A < B + Bin (unsigned).
  - out_zero is derived from the final acc value, including the last nibble written on the same edge.
- **Reset** (in_rst_n=0 at a rising edge, including mid-RUN):
  - state returns to IDLE, idx=0, borrow_reg=0, a_reg/b_reg/acc = 0.
  - out_busy=0, out_done=0, out_diff=0, out_bout=0, out_zero=0.
  - Any in-flight operation is discarded and no done pulse is produced.
  - in_start asserted during reset is ignored.

## Timing

- The accepting start edge is edge 0.
- out_busy=1 after edges 0..N_NIBBLES−1, covering N_NIBBLES cycles.
- Nibble k is computed in the cycle after edge k and registered on edge k+1.
- The edge that registers nibble N_NIBBLES−1 enters DONE: out_done=1 for one cycle, beginning after edge N_NIBBLES.
- Latency from start to done is N_NIBBLES+1 edges.
- Maximum throughput is one operation per N_NIBBLES+1 cycles, using back-to-back start in DONE.
- out_busy and out_done are never high simultaneously.
- The critical path is one 4-bit ripple plus the nibble mux/demux; it is independent of N_NIBBLES except through mux depth.

## Structure

- **Shared package nibble_sub_pkg:** holds the state enum (IDLE, RUN, DONE) and the nibble width constant (4).
- **Sub-module sub_slice4:** a combinational 4-bit ripple-borrow subtractor (a, b, borrow-in → diff, borrow-out) built from 1-bit subtractor cells. It is instantiated once.
- **Controller:** the FSM, idx counter, operand registers, accumulator and output registers.

## Test plan

All scenarios use N_NIBBLES=4.

1. in_a=0x1234, in_b=0x0235, in_bin=0, start pulse.
   - Required: out_busy high for 4 cycles, then out_done one cycle.
   - Required result: out_diff=0x0FFF, out_bout=0, out_zero=0.
2. in_a=0x0000, in_b=0x0001, in_bin=0.
   - Required: out_diff=0xFFFF, out_bout=1, out_zero=0.
3. in_a=0x8000, in_b=0x7FFF, in_bin=1.
   - Required: out_diff=0x0000, out_zero=1, out_bout=0. This exercises the borrow across all nibble boundaries.
4. Start 0x0005−0x0003; hold in_start=1 and change in_a/in_b during RUN; assert in_start again in DONE with 0x0010−0x0001.
   - Required: first done has out_diff=0x0002 (the mid-RUN changes are ignored).
   - Required: second op starts with no IDLE cycle; second done has out_diff=0x000F.
5. Start an op; pull in_rst_n=0 at edge 2 of RUN for one cycle.
   - Required: next cycle all outputs are 0, state is IDLE, and no out_done pulse appears.
   - Required: a subsequent 0x00FF−0x000F completes normally with out_diff=0x00F0.
6. Random A, B, Bin (≥1000 ops) with random start gaps.
   - Required: a scoreboard matches (A−B−Bin) mod 2^16 and the borrow-out.
   - Required: result registers stay stable between done pulses.

Source files
------------

// File: rtl/nibble_sub_pkg.sv
// ---------------------------------------------------------------------------
// nibble_sub_pkg
// Shared definitions for the nibble-serial subtractor: the nibble width
// handled by the shared slice and the controller state encoding.
// ---------------------------------------------------------------------------
package nibble_sub_pkg;

    localparam int NIBBLE_W = 4;

    // Two-bit encoding; the fourth code is never entered.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sub_slice4.sv
// ---------------------------------------------------------------------------
// sub_slice4
// Combinational 4-bit ripple-borrow subtractor: o_diff = i_a - i_b - i_bin.
// It is built from four 1-bit subtractor cells chained through their borrows.
//
// Ports:
//   i_a    [3:0]  minuend nibble
//   i_b    [3:0]  subtrahend nibble
//   i_bin         borrow into bit 0
//   o_diff [3:0]  difference nibble
//   o_bout        borrow out of bit 3 (1 means i_a < i_b + i_bin)
// ---------------------------------------------------------------------------
module sub_slice4
    import nibble_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_bin,
    output logic [NIBBLE_W-1:0] o_diff,
    output logic                o_bout
);

    logic [NIBBLE_W:0] w_borrow;

    assign w_borrow[0] = i_bin;

    // Each cell is a full subtractor. It borrows when its minuend bit is 0
    // and its subtrahend bit is 1, or when the two bits are equal and a
    // borrow arrives from the cell below.
    for (genvar g = 0; g < NIBBLE_W; g++) begin : g_cell
        assign o_diff[g]     = i_a[g] ^ i_b[g] ^ w_borrow[g];
        assign w_borrow[g+1] = (~i_a[g] & i_b[g]) | (~(i_a[g] ^ i_b[g]) & w_borrow[g]);
    end

    assign o_bout = w_borrow[NIBBLE_W];

endmodule

// File: rtl/nibble_sub_seq.sv
// ---------------------------------------------------------------------------
// nibble_sub_seq
// Sequential W-bit subtractor, where W = 4*N_NIBBLES. A single 4-bit slice
// computes A - B - Bin one nibble per cycle, least-significant nibble first.
// A register carries the borrow from one cycle to the next.
//
// Ports:
//   in_clk, in_rst_n   clock; synchronous active-low reset
//   in_start           request; accepted in IDLE or DONE
//   in_a, in_b, in_bin operands, captured on the accepting edge
//   out_busy           high while the slice is being stepped (RUN)
//   out_done           one-cycle pulse when the result registers update
//   out_diff           (A - B - Bin) mod 2^W
//   out_bout           final borrow-out (A < B + Bin, unsigned)
//   out_zero           out_diff == 0
// ---------------------------------------------------------------------------
module nibble_sub_seq
    import nibble_sub_pkg::*;
#(
    parameter int N_NIBBLES = 4
) (
    input  logic                        in_clk,
    input  logic                        in_rst_n,
    input  logic                        in_start,
    input  logic [4*N_NIBBLES-1:0]      in_a,
    input  logic [4*N_NIBBLES-1:0]      in_b,
    input  logic                        in_bin,
    output logic                        out_busy,
    output logic                        out_done,
    output logic [4*N_NIBBLES-1:0]      out_diff,
    output logic                        out_bout,
    output logic                        out_zero
);

    localparam int W     = NIBBLE_W * N_NIBBLES;
    localparam int IDX_W = $clog2(N_NIBBLES);

    state_t              r_state;
    state_t              w_nextState;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_acc;
    logic                r_borrow;
    logic [W-1:0]        r_diff;
    logic                r_bout;
    logic                r_zero;

    logic                w_accept;
    logic                w_lastNibble;
    logic [IDX_W+1:0]    w_base;
    logic [NIBBLE_W-1:0] w_sliceA;
    logic [NIBBLE_W-1:0] w_sliceB;
    logic [NIBBLE_W-1:0] w_sliceDiff;
    logic                w_sliceBout;
    logic [W-1:0]        w_accNext;

    // A request is taken in IDLE, or in DONE for back-to-back operation.
    // In RUN, in_start is ignored entirely.
    assign w_accept     = in_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastNibble = (r_idx == IDX_W'(N_NIBBLES - 1));
    assign w_base       = {r_idx, 2'b00};

    assign w_sliceA = r_a[w_base +: NIBBLE_W];
    assign w_sliceB = r_b[w_base +: NIBBLE_W];

    sub_slice4 u_slice (
        .i_a    (w_sliceA),
        .i_b    (w_sliceB),
        .i_bin  (r_borrow),
        .o_diff (w_sliceDiff),
        .o_bout (w_sliceBout)
    );

    // The accumulator with this cycle's nibble merged in. The zero flag is
    // derived from this value so that it sees the nibble written on the
    // edge that enters DONE.
    always_comb begin
        w_accNext = r_acc;
        w_accNext[w_base +: NIBBLE_W] = w_sliceDiff;
    end

    // State register.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN lasts exactly N_NIBBLES cycles and DONE lasts
    // one cycle. The unused code falls back to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = w_accept ? RUN : IDLE;
            RUN:     w_nextState = w_lastNibble ? DONE : RUN;
            DONE:    w_nextState = w_accept ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode. It follows the state alone, so busy and done can never
    // be high at the same time.
    always_comb begin
        out_busy = 1'b0;
        out_done = 1'b0;
        case (r_state)
            RUN:     out_busy = 1'b1;
            DONE:    out_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, nibble stepping and borrow chaining. The
    // result registers load only on the edge that writes the last nibble.
    // This lets them hold through IDLE and through the next RUN.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_a      <= in_a;
            r_b      <= in_b;
            r_acc    <= '0;
            r_borrow <= in_bin;
        end else if (r_state == RUN) begin
            r_acc    <= w_accNext;
            r_borrow <= w_sliceBout;
            r_idx    <= w_lastNibble ? '0 : r_idx + IDX_W'(1);
            if (w_lastNibble) begin
                r_diff <= w_accNext;
                r_bout <= w_sliceBout;
                r_zero <= (w_accNext == '0);
            end
        end
    end

    assign out_diff = r_diff;
    assign out_bout = r_bout;
    assign out_zero = r_zero;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_sub_seq
// Scoreboard bench for nibble_sub_seq with N_NIBBLES=4. Stimulus pushes
// expected results into a queue. A negedge monitor pops from the queue on
// every done pulse, and also checks that the results hold between pulses.
// ---------------------------------------------------------------------------
module tb_nibble_sub_seq;
    import nibble_sub_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rstN  = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    bit           monEn = 1'b0;
    bit           rstAtEdge = 1'b0;
    logic [W-1:0] lastDiff = '0;
    logic         lastBout = 1'b0;
    logic         lastZero = 1'b0;

    nibble_sub_seq #(.N_NIBBLES(N)) dut (
        .in_clk   (clk),
        .in_rst_n (rstN),
        .in_start (start),
        .in_a     (a),
        .in_b     (b),
        .in_bin   (bin),
        .out_busy (busy),
        .out_done (done),
        .out_diff (diff),
        .out_bout (bout),
        .out_zero (zero)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Safety net in case the design never reaches the end of the test.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model, written as plain integer arithmetic on the full words.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t e;
        int   full;
        full   = int'(ma) - int'(mb) - int'(mbin);
        e.diff = full[W-1:0];
        e.bout = (full < 0);
        e.zero = (e.diff == '0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Remember whether the last rising edge applied reset. The monitor then
    // knows that the result registers were cleared at that edge.
    always @(posedge clk) rstAtEdge <= !rstN;

    // Monitor. On a done pulse it compares the outputs against the head of
    // the scoreboard. On every other cycle it checks that the results still
    // hold the last expected values.
    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("busyDoneExclusive", {31'b0, busy & done}, 32'd0);
            if (rstAtEdge) begin
                lastDiff = '0;
                lastBout = 1'b0;
                lastZero = 1'b0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedDone: got done pulse with diff=0x%0h, expected no pulse", diff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("doneDiff", 32'(diff), 32'(e.diff));
                    checkOutput("doneBout", 32'(bout), 32'(e.bout));
                    checkOutput("doneZero", 32'(zero), 32'(e.zero));
                    lastDiff = e.diff;
                    lastBout = e.bout;
                    lastZero = e.zero;
                end
            end else begin
                checkOutput("holdDiff", 32'(diff), 32'(lastDiff));
                checkOutput("holdBout", 32'(bout), 32'(lastBout));
                checkOutput("holdZero", 32'(zero), 32'(lastZero));
            end
        end
    end

    // Waits at negedges for a done pulse, within a fixed cycle budget.
    task automatic waitDone(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no done within %0d cycles, expected done pulse", name, budget);
    endtask

    // Issues one request. It must be called at a negedge while the DUT is in
    // IDLE or DONE. The operands are scrambled during RUN to show that only
    // the values captured at the accepting edge are used.
    task automatic applyStimulus(input string name, input logic [W-1:0] sa, input logic [W-1:0] sb2,
                                 input logic sbin, input exp_t e);
        a     = sa;
        b     = sb2;
        bin   = sbin;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        waitDone(name, 20);
    endtask

    initial begin
        int   doneCount;
        bit   gotDone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        // Reset, with start held high to show that it is ignored.
        rstN  = 1'b0;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h0001;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetDiff", 32'(diff), 32'd0);
        checkOutput("resetBout", 32'(bout), 32'd0);
        checkOutput("resetZero", 32'(zero), 32'd0);
        checkOutput("resetState", 32'(dut.r_state), 32'(IDLE));
        start = 1'b0;
        rstN  = 1'b1;
        monEn = 1'b1;
        @(negedge clk);

        // Scenario 1: busy for four cycles, then a single done cycle.
        a     = 16'h1234;
        b     = 16'h0235;
        bin   = 1'b0;
        start = 1'b1;
        sb.push_back('{diff: 16'h0FFF, bout: 1'b0, zero: 1'b0});
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("s1Busy%0d", k), 32'(busy), 32'd1);
            checkOutput($sformatf("s1NotDone%0d", k), 32'(done), 32'd0);
            @(negedge clk);
        end
        checkOutput("s1Done", 32'(done), 32'd1);
        checkOutput("s1NotBusy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("s1DoneOneCycle", 32'(done), 32'd0);

        // Scenario 2: underflow produces a borrow-out.
        applyStimulus("s2", 16'h0000, 16'h0001, 1'b0, '{diff: 16'hFFFF, bout: 1'b1, zero: 1'b0});
        @(negedge clk);

        // Scenario 3: a borrow that ripples across every nibble, with a zero result.
        applyStimulus("s3", 16'h8000, 16'h7FFF, 1'b1, '{diff: 16'h0000, bout: 1'b0, zero: 1'b1});
        @(negedge clk);

        // Scenario 4: start held high and operands changed during RUN, then a
        // back-to-back request issued in DONE.
        a     = 16'h0005;
        b     = 16'h0003;
        bin   = 1'b0;
        start = 1'b1;
        sb.push_back('{diff: 16'h0002, bout: 1'b0, zero: 1'b0});
        gotDone = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            a = W'($urandom);
            b = W'($urandom);
        end
        if (!gotDone) begin
            checks++;
            errors++;
            $display("[TB] FAIL s4First: got no done, expected done pulse");
        end
        a = 16'h0010;
        b = 16'h0001;
        sb.push_back('{diff: 16'h000F, bout: 1'b0, zero: 1'b0});
        @(negedge clk);
        start = 1'b0;
        checkOutput("s4BackToBackBusy", 32'(busy), 32'd1);
        waitDone("s4Second", 20);
        @(negedge clk);

        // Scenario 5: reset in the middle of RUN discards the operation.
        a     = 16'h1111;
        b     = 16'h0101;
        bin   = 1'b0;
        start = 1'b1;
        sb.push_back(model(16'h1111, 16'h0101, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rstN  = 1'b0;
        @(negedge clk);
        rstN  = 1'b1;
        sb.delete();
        checkOutput("s5Busy", 32'(busy), 32'd0);
        checkOutput("s5Done", 32'(done), 32'd0);
        checkOutput("s5Diff", 32'(diff), 32'd0);
        checkOutput("s5Bout", 32'(bout), 32'd0);
        checkOutput("s5Zero", 32'(zero), 32'd0);
        checkOutput("s5State", 32'(dut.r_state), 32'(IDLE));
        doneCount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("s5NoDone", 32'(doneCount), 32'd0);
        applyStimulus("s5After", 16'h00FF, 16'h000F, 1'b0, '{diff: 16'h00F0, bout: 1'b0, zero: 1'b0});
        @(negedge clk);

        // Scenario 6: random operands with random gaps. A gap of zero issues
        // the next request during DONE, back-to-back.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 15) == 0) begin
                ra = '0;
                rb = '1;
            end
            applyStimulus("s6Random", ra, rb, rbin, model(ra, rb, rbin));
        end

        @(negedge clk);
        checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
        monEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
